pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage processor. Each cycle it drives the enable inputs of the PC, F/D, D/X, X/M and M/W latches, plus the flush/bubble selects that force a nop into a latch. It resolves three conditions: load-use hazards, taken branches/jumps resolved in X, and multi-cycle mul/div operations in X. It sits beside the latch chain in the processor top level and has no datapath of its own.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_hazard_ctrl_insn_src_decode.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: instruction
// field positions, opcode/aluop constants and the controller state enum.
package pipe_ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  // Opcodes
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type aluop codes handled by the multi-cycle unit
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  // True when the opcode/aluop pair selects the multi-cycle mul/div unit
  function automatic logic is_muldiv(input logic [4:0] opcode,
                                     input logic [4:0] aluop);
    return (opcode == OP_RTYPE) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_insn_src_decode.sv
// Combinational source-register decode: extracts rs/rt/rd and flags which
// of them the instruction actually reads as operands.
module insn_src_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] insn,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        use_rs,
  output logic        use_rt,
  output logic        use_rd
);

  logic [4:0]  opcode;
  logic [11:0] insn_unused_bits;

  assign opcode           = insn[OPC_HI:OPC_LO];
  assign rs               = insn[RS_HI:RS_LO];
  assign rt               = insn[RT_HI:RT_LO];
  assign rd               = insn[RD_HI:RD_LO];
  // Immediate/aluop/shamt bits play no part in operand usage
  assign insn_unused_bits = insn[11:0];

  // Operand-use flags by opcode class
  always_comb begin
    use_rs = 1'b1;
    use_rt = 1'b0;
    use_rd = 1'b0;
    if ((opcode == OP_J) || (opcode == OP_JAL) ||
        (opcode == OP_SETX) || (opcode == OP_BEX)) begin
      use_rs = 1'b0;
    end
    if (opcode == OP_RTYPE) begin
      use_rt = 1'b1;
    end
    if ((opcode == OP_SW) || (opcode == OP_BNE) ||
        (opcode == OP_JR) || (opcode == OP_BLT)) begin
      use_rd = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Drives latch enables
// and nop-insertion selects to resolve load-use hazards, taken control
// transfers resolved in X, and multi-cycle mul/div operations in X.
// Optional macro PIPE_HAZARD_CTRL_MD_TIMEOUT_EN adds a bounded mul/div wait
// with a forced release after MD_TIMEOUT cycles and a sticky md_timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        xm_bubble,
  output logic        md_start,
  output logic        md_busy,
  output logic        md_timeout
);

  state_e      state_q;
  state_e      state_d;

  logic [4:0]  fd_rs;
  logic [4:0]  fd_rt;
  logic [4:0]  fd_rd;
  logic        fd_use_rs;
  logic        fd_use_rt;
  logic        fd_use_rd;

  logic [4:0]  dx_opcode;
  logic [4:0]  dx_rd;
  logic [4:0]  dx_aluop;
  logic [16:0] dx_unused_bits;

  logic        dx_is_md;
  logic        load_use;
  logic        timeout_hit;
  logic        md_timeout_q;

  insn_src_decode u_fd_decode (
    .insn   (fd_insn),
    .rs     (fd_rs),
    .rt     (fd_rt),
    .rd     (fd_rd),
    .use_rs (fd_use_rs),
    .use_rt (fd_use_rt),
    .use_rd (fd_use_rd)
  );

  assign dx_opcode      = dx_insn[OPC_HI:OPC_LO];
  assign dx_rd          = dx_insn[RD_HI:RD_LO];
  assign dx_aluop       = dx_insn[ALU_HI:ALU_LO];
  assign dx_unused_bits = {dx_insn[RS_HI:7], dx_insn[1:0]};

  assign dx_is_md = is_muldiv(dx_opcode, dx_aluop);

  // A load's destination feeding any operand the next instruction reads
  assign load_use = (dx_opcode == OP_LW) && (dx_rd != 5'd0) &&
                    ((fd_use_rs && (fd_rs == dx_rd)) ||
                     (fd_use_rt && (fd_rt == dx_rd)) ||
                     (fd_use_rd && (fd_rd == dx_rd)));

`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt_q;

  assign timeout_hit = (state_q == MD_WAIT) &&
                       (wait_cnt_q == CNT_W'(MD_TIMEOUT - 1));

  // Wait counter held at zero in RUN so it starts from zero on each entry;
  // sticky flag records any forced release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q   <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      if (state_q == MD_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
      if (timeout_hit && !md_ready) begin
        md_timeout_q <= 1'b1;
      end
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused   = (MD_TIMEOUT > 0);
  assign timeout_hit  = 1'b0;
  assign md_timeout_q = 1'b0;
`endif

  // Controller state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and latch-control decode, all outputs forced low in reset
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    fd_en      = 1'b0;
    dx_en      = 1'b0;
    xm_en      = 1'b0;
    mw_en      = 1'b0;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_bubble  = 1'b0;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    md_timeout = md_timeout_q;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          // Squash the two wrong-path instructions behind the branch
          pc_en    = 1'b1;
          fd_en    = 1'b1;
          dx_en    = 1'b1;
          xm_en    = 1'b1;
          mw_en    = 1'b1;
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (dx_is_md) begin
          // Launch mul/div, freeze front end, drain back end with bubbles
          md_start  = 1'b1;
          xm_en     = 1'b1;
          mw_en     = 1'b1;
          xm_bubble = 1'b1;
          state_d   = MD_WAIT;
        end else if (load_use) begin
          // Hold the consumer in F/D one cycle while lw moves to X/M
          dx_en    = 1'b1;
          xm_en    = 1'b1;
          mw_en    = 1'b1;
          dx_flush = 1'b1;
        end else begin
          pc_en = 1'b1;
          fd_en = 1'b1;
          dx_en = 1'b1;
          xm_en = 1'b1;
          mw_en = 1'b1;
        end
      end

      MD_WAIT: begin
        md_busy = 1'b1;
        xm_en   = 1'b1;
        mw_en   = 1'b1;
        if (md_ready || timeout_hit) begin
          pc_en   = 1'b1;
          fd_en   = 1'b1;
          dx_en   = 1'b1;
          state_d = RUN;
        end else begin
          xm_bubble = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (!reset) begin
      pc_en      = 1'b0;
      fd_en      = 1'b0;
      dx_en      = 1'b0;
      xm_en      = 1'b0;
      mw_en      = 1'b0;
      fd_flush   = 1'b0;
      dx_flush   = 1'b0;
      xm_bubble  = 1'b0;
      md_start   = 1'b0;
      md_busy    = 1'b0;
      md_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios against
// fixed expected control vectors, then randomized traffic against a
// behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;

  localparam int MD_TO = 8;

  // Expected vector order:
  // {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble,
  //  md_start, md_busy, md_timeout}
  localparam logic [10:0] V_ZERO   = 11'b00000_000_000;
  localparam logic [10:0] V_RUN    = 11'b11111_000_000;
  localparam logic [10:0] V_LDUSE  = 11'b00111_010_000;
  localparam logic [10:0] V_BRANCH = 11'b11111_110_000;
  localparam logic [10:0] V_MDST   = 11'b00011_001_100;
  localparam logic [10:0] V_MDHOLD = 11'b00011_001_010;
  localparam logic [10:0] V_MDREL  = 11'b11111_000_010;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fd_insn = '0;
  logic [31:0] dx_insn = '0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_flush, dx_flush, xm_bubble;
  logic        md_start, md_busy, md_timeout;
  logic [10:0] got;

  int checks = 0;
  int errors = 0;

  // Reference model state: waiting on mul/div, cycles already spent
  // waiting, sticky timeout flag
  bit m_wait = 1'b0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;

  pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_insn      (fd_insn),
    .dx_insn      (dx_insn),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .xm_en        (xm_en),
    .mw_en        (mw_en),
    .fd_flush     (fd_flush),
    .dx_flush     (dx_flush),
    .xm_bubble    (xm_bubble),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_timeout   (md_timeout)
  );

  assign got = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush,
                xm_bubble, md_start, md_busy, md_timeout};

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Does instruction insn read register r as an operand?
  function automatic bit reads_reg(input logic [31:0] insn, input logic [4:0] r);
    logic [4:0] op;
    bit rs_hit, rt_hit, rd_hit;
    op = insn[31:27];
    rs_hit = !(op inside {5'd1, 5'd3, 5'd21, 5'd22}) && (insn[21:17] == r);
    rt_hit = (op == 5'd0) && (insn[16:12] == r);
    rd_hit = (op inside {5'd7, 5'd2, 5'd4, 5'd6}) && (insn[26:22] == r);
    return rs_hit || rt_hit || rd_hit;
  endfunction

  function automatic bit is_md(input logic [31:0] insn);
    return (insn[31:27] == 5'd0) && ((insn[6:2] == 5'd6) || (insn[6:2] == 5'd7));
  endfunction

  function automatic bit forced_release();
`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
    return m_cnt == MD_TO - 1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs for the current model state and driven inputs
  function automatic logic [10:0] model_out();
    logic to;
    logic [4:0] lw_rd;
    to = m_to;
    lw_rd = dx_insn[26:22];
    if (!reset) return V_ZERO;
    if (m_wait) begin
      if (md_ready || forced_release()) return V_MDREL | {10'b0, to};
      return V_MDHOLD | {10'b0, to};
    end
    if (branch_taken) return V_BRANCH | {10'b0, to};
    if (is_md(dx_insn)) return V_MDST | {10'b0, to};
    if (dx_insn[31:27] == 5'd8 && lw_rd != 5'd0 && reads_reg(fd_insn, lw_rd))
      return V_LDUSE | {10'b0, to};
    return V_RUN | {10'b0, to};
  endfunction

  // Advance one clock edge, moving the model in step with the DUT
  task automatic tick();
    bit nw = m_wait;
    int nc = m_cnt;
    bit nt = m_to;
    if (!reset) begin
      nw = 1'b0; nc = 0; nt = 1'b0;
    end else if (!m_wait) begin
      if (!branch_taken && is_md(dx_insn)) begin
        nw = 1'b1; nc = 0;
      end
    end else if (md_ready || forced_release()) begin
      nw = 1'b0;
      if (!md_ready) nt = 1'b1;
    end else begin
      nc = m_cnt + 1;
    end
    @(posedge clock);
    #1;
    m_wait = nw; m_cnt = nc; m_to = nt;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    r = $urandom;
    r[26:22] = 5'($urandom_range(0, 3));
    r[21:17] = 5'($urandom_range(0, 3));
    r[16:12] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0, 1: r[31:27] = 5'd8;
      2: begin r[31:27] = 5'd0; r[6:2] = 5'($urandom_range(6, 7)); end
      3: r[31:27] = 5'd0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      fd_insn = rand_insn(); dx_insn = rand_insn();
      branch_taken = 1'($urandom); md_ready = 1'($urandom);
      #1;
      checks++;
      if (got !== V_ZERO) begin
        errors++; $display("FAIL reset_outputs got=%b exp=%b", got, V_ZERO);
      end
      tick();
    end
    fd_insn = '0; dx_insn = '0; branch_taken = 1'b0; md_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", got, V_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    dx_insn = itype(5'd8, 5'd5, 5'd1, 17'd0);
    fd_insn = rtype(5'd2, 5'd5, 5'd3, 5'd0);
    #1;
    checks++;
    if (got !== V_LDUSE) begin
      errors++; $display("FAIL load_use_stall got=%b exp=%b", got, V_LDUSE);
    end
    tick();
    dx_insn = '0;
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL load_use_one_cycle got=%b exp=%b", got, V_RUN);
    end
    dx_insn = itype(5'd8, 5'd0, 5'd1, 17'd0);
    fd_insn = rtype(5'd2, 5'd0, 5'd3, 5'd0);
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL load_use_r0 got=%b exp=%b", got, V_RUN);
    end
    dx_insn = itype(5'd8, 5'd5, 5'd1, 17'd0);
    fd_insn = itype(5'd7, 5'd5, 5'd2, 17'd4);
    #1;
    checks++;
    if (got !== V_LDUSE) begin
      errors++; $display("FAIL load_use_sw_rd got=%b exp=%b", got, V_LDUSE);
    end
    fd_insn = itype(5'd1, 5'd5, 5'd5, 17'd4);
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL load_use_jump_noread got=%b exp=%b", got, V_RUN);
    end
    fd_insn = itype(5'd5, 5'd7, 5'd1, 17'd5);
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL load_use_itype_rt got=%b exp=%b", got, V_RUN);
    end
    tick();
  endtask

  task automatic test_branch();
    dx_insn = itype(5'd8, 5'd5, 5'd1, 17'd0);
    fd_insn = rtype(5'd2, 5'd5, 5'd3, 5'd0);
    branch_taken = 1'b1;
    #1;
    checks++;
    if (got !== V_BRANCH) begin
      errors++; $display("FAIL branch_over_load_use got=%b exp=%b", got, V_BRANCH);
    end
    tick();
    branch_taken = 1'b0; dx_insn = '0; fd_insn = '0;
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL branch_after got=%b exp=%b", got, V_RUN);
    end
    tick();
  endtask

  task automatic test_mul();
    dx_insn = rtype(5'd1, 5'd2, 5'd3, 5'd6);
    fd_insn = '0; md_ready = 1'b0;
    #1;
    checks++;
    if (got !== V_MDST) begin
      errors++; $display("FAIL mul_start got=%b exp=%b", got, V_MDST);
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      branch_taken = (c == 2);
      #1;
      checks++;
      if (got !== V_MDHOLD) begin
        errors++; $display("FAIL mul_wait_c%0d got=%b exp=%b", c, got, V_MDHOLD);
      end
      tick();
    end
    branch_taken = 1'b0; md_ready = 1'b1;
    #1;
    checks++;
    if (got !== V_MDREL) begin
      errors++; $display("FAIL mul_release got=%b exp=%b", got, V_MDREL);
    end
    tick();
    dx_insn = '0; md_ready = 1'b0;
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL mul_back_to_run got=%b exp=%b", got, V_RUN);
    end
    tick();
  endtask

  task automatic test_early_ready();
    dx_insn = rtype(5'd1, 5'd2, 5'd3, 5'd0);
    md_ready = 1'b1;
    #1;
    checks++;
    if (got !== V_RUN) begin
      errors++; $display("FAIL early_ready_run got=%b exp=%b", got, V_RUN);
    end
    tick();
    dx_insn = rtype(5'd1, 5'd2, 5'd3, 5'd7);
    #1;
    checks++;
    if (got !== V_MDST) begin
      errors++; $display("FAIL div_start_ready_high got=%b exp=%b", got, V_MDST);
    end
    tick();
    #1;
    checks++;
    if (got !== V_MDREL) begin
      errors++; $display("FAIL div_release_c1 got=%b exp=%b", got, V_MDREL);
    end
    tick();
    dx_insn = '0; md_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mdwait();
    dx_insn = rtype(5'd4, 5'd2, 5'd3, 5'd7);
    md_ready = 1'b0;
    tick(); tick(); tick();
    #1;
    checks++;
    if (got !== V_MDHOLD) begin
      errors++; $display("FAIL mdwait_c3 got=%b exp=%b", got, V_MDHOLD);
    end
    reset = 1'b0; md_ready = 1'b1;
    #1;
    checks++;
    if (got !== V_ZERO) begin
      errors++; $display("FAIL reset_in_mdwait got=%b exp=%b", got, V_ZERO);
    end
    tick();
    reset = 1'b1; dx_insn = '0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || got !== V_RUN) begin
      errors++; $display("FAIL after_reset_run got=%b exp=%b", got, V_RUN);
    end
    md_ready = 1'b0;
    tick();
  endtask

`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
  task automatic test_timeout();
    dx_insn = rtype(5'd1, 5'd2, 5'd3, 5'd6);
    md_ready = 1'b0;
    #1;
    checks++;
    if (got !== V_MDST) begin
      errors++; $display("FAIL to_start got=%b exp=%b", got, V_MDST);
    end
    tick();
    for (int c = 1; c < MD_TO; c++) begin
      #1;
      checks++;
      if (got !== V_MDHOLD) begin
        errors++; $display("FAIL to_wait_c%0d got=%b exp=%b", c, got, V_MDHOLD);
      end
      tick();
    end
    #1;
    checks++;
    if (got !== V_MDREL) begin
      errors++; $display("FAIL to_forced_release got=%b exp=%b", got, V_MDREL);
    end
    tick();
    dx_insn = '0;
    #1;
    checks++;
    if (got !== (V_RUN | 11'b1)) begin
      errors++; $display("FAIL to_sticky got=%b exp=%b", got, V_RUN | 11'b1);
    end
    tick();
    #1;
    checks++;
    if (md_timeout !== 1'b1) begin
      errors++; $display("FAIL to_held got=%b exp=1", md_timeout);
    end
  endtask
`endif

  task automatic test_random();
    logic [10:0] exp;
    for (int i = 0; i < 600; i++) begin
      fd_insn = rand_insn();
      dx_insn = rand_insn();
      branch_taken = ($urandom_range(0, 7) == 0);
      md_ready = m_wait ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      reset = ($urandom_range(0, 79) != 0);
      #1;
      exp = model_out();
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_c%0d got=%b exp=%b", i, got, exp);
      end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_early_ready();
    test_reset_mdwait();
`ifdef PIPE_HAZARD_CTRL_MD_TIMEOUT_EN
    test_timeout();
`else
    #1;
    checks++;
    if (md_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_tied_low got=%b exp=0", md_timeout);
    end
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
